// File: rtl/vexp_vec_seq.sv
// Vector-to-scalar sequencer around the scalar exp unit: issues the unmasked
// elements one per cycle, gathers in-order results back into a vector.
module vexp_vec_seq #(
    parameter int NUM_ELEMS = 32,
    parameter int DW        = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    vec_valid_in,
    output logic                    vec_ready_out,
    input  logic [NUM_ELEMS*DW-1:0] vec_operand,
    input  logic [NUM_ELEMS-1:0]    vec_mask,
    output logic                    vec_valid_out,
    input  logic                    vec_ready_in,
    output logic [NUM_ELEMS*DW-1:0] vec_result,
    output logic [DW-1:0]           exu_operand,
    output logic                    exu_valid,
    input  logic                    exu_ready,
    input  logic [DW-1:0]           exu_result,
    input  logic                    exu_res_valid,
    output logic                    exu_res_ready
);

    localparam int PW = $clog2(NUM_ELEMS);

    typedef logic [PW:0] ptr_t;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t state, state_nxt;

    logic [DW-1:0]        op_q  [NUM_ELEMS];
    logic [DW-1:0]        res_q [NUM_ELEMS];
    logic [DW-1:0]        in_op [NUM_ELEMS];
    logic [NUM_ELEMS-1:0] mask_q;
    ptr_t                 issue_ptr;
    ptr_t                 collect_ptr;
    ptr_t                 first_ptr;
    ptr_t                 issue_nxt;
    ptr_t                 collect_nxt;
    logic                 exu_valid_q;
    logic [DW-1:0]        exu_operand_q;
    logic                 accept;
    logic                 issue_fire;
    logic                 collect_fire;

    // Lowest set mask bit at or above 'from'; MSB (done bit) set when none.
    function automatic ptr_t next_set(
        input logic [NUM_ELEMS-1:0] m,
        input ptr_t                 from
    );
        ptr_t r;
        logic found;
        r     = ptr_t'(NUM_ELEMS);
        found = 1'b0;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            if (!found && m[i] && (ptr_t'(i) >= from)) begin
                r     = ptr_t'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_ELEMS; i++) begin
            in_op[i]               = vec_operand[i*DW +: DW];
            vec_result[i*DW +: DW] = res_q[i];
        end
    end

    assign first_ptr   = next_set(vec_mask, '0);
    assign issue_nxt   = next_set(mask_q, issue_ptr + 1'b1);
    assign collect_nxt = next_set(mask_q, collect_ptr + 1'b1);

    assign accept       = vec_valid_in && vec_ready_out;
    assign issue_fire   = exu_valid_q && exu_ready;
    assign collect_fire = exu_res_valid && exu_res_ready;
    assign exu_valid    = exu_valid_q;
    assign exu_operand  = exu_operand_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        vec_ready_out = 1'b0;
        vec_valid_out = 1'b0;
        exu_res_ready = 1'b0;
        unique case (state)
            IDLE: begin
                vec_ready_out = 1'b1;
                if (vec_valid_in) begin
                    state_nxt = (vec_mask != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                exu_res_ready = 1'b1;
                if (exu_res_valid && collect_nxt[PW]) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                vec_valid_out = 1'b1;
                if (vec_ready_in) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Issue and collect sides advance independently inside RUN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mask_q        <= '0;
            issue_ptr     <= '0;
            collect_ptr   <= '0;
            exu_valid_q   <= 1'b0;
            exu_operand_q <= '0;
            op_q          <= '{default: '0};
            res_q         <= '{default: '0};
        end else if (accept) begin
            op_q          <= in_op;
            mask_q        <= vec_mask;
            res_q         <= '{default: '0};
            issue_ptr     <= first_ptr;
            collect_ptr   <= first_ptr;
            exu_valid_q   <= !first_ptr[PW];
            exu_operand_q <= first_ptr[PW] ? '0 : in_op[first_ptr[PW-1:0]];
        end else begin
            if (issue_fire) begin
                issue_ptr     <= issue_nxt;
                exu_valid_q   <= !issue_nxt[PW];
                exu_operand_q <= issue_nxt[PW] ? '0 : op_q[issue_nxt[PW-1:0]];
            end
            if (collect_fire) begin
                res_q[collect_ptr[PW-1:0]] <= exu_result;
                collect_ptr                <= collect_nxt;
            end
        end
    end

endmodule

// File: doc/vexp_vec_seq.md
Name: vexp_vec_seq

Overview:
- Vector-to-scalar sequencer directly upstream and downstream of the scalar vector-exp unit.
- Accepts one whole vector of NUM_ELEMS 16-bit (bf16) elements plus a lane mask.
- Issues the unmasked elements one per cycle into the exp unit's operand/valid/ready handshake, then collects the in-order results into a result vector.
- Presents the completed vector downstream, for example to the softmax reduction path.

Parameters:
NUM_ELEMS, 32, elements per vector (power of two, 2..64)
DW, 16, element width in bits (bf16)

Ports:
CLK  in  1  clock, all logic on rising edge
RST  in  1  synchronous active-high reset
vec_valid_in  in  1  upstream vector valid
vec_ready_out  out  1  sequencer can accept a vector
vec_operand  in  NUM_ELEMS*DW  input vector, element i at [i*DW +: DW]
vec_mask  in  NUM_ELEMS  1 = element active; 0 = element result forced to 16'h0000
vec_valid_out  out  1  result vector valid
vec_ready_in  in  1  downstream accepts result vector
vec_result  out  NUM_ELEMS*DW  result vector, same element layout
exu_operand  out  DW  element to exp unit (drives unit operand)
exu_valid  out  1  drives unit valid_in
exu_ready  in  1  from unit ready_in
exu_result  in  DW  from unit result
exu_res_valid  in  1  from unit valid_out
exu_res_ready  out  1  drives unit ready_out

Behaviour:
- Reset (RST=1 at a clock edge, regardless of state): state=IDLE; vec_ready_out=1; vec_valid_out=0; exu_valid=0; exu_res_ready=0; exu_operand=0; vec_result=0; internal pointers and mask=0. Any in-flight vector is discarded. The exp unit shares the same reset, so no stale results return.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - vec_ready_out=1.
  - On vec_valid_in&vec_ready_out: latch operand and mask, clear result buffer to 0, and set issue/collect pointers to the first set mask bit.
  - Go to RUN if mask!=0, else go to DONE (all-zero vector, valid the next cycle).
- RUN:
  - vec_ready_out=0; exu_res_ready=1.
  - Issue side:
    - exu_valid=1 and exu_operand=operand[issue_ptr] while issued_count < popcount(mask).
    - On exu_valid&exu_ready, issue_ptr advances to the next set mask bit above the current one.
    - exu_valid is registered and held stable with an unchanged operand until the handshake completes.
    - Masked elements cost no cycles.
  - Collect side:
    - On exu_res_valid&exu_res_ready, result_buf[collect_ptr]=exu_result and collect_ptr advances to the next set mask bit.
    - Results are strictly in issue order.
  - Issue and collect handshakes may occur in the same cycle and are independent.
  - When the final active element is collected, go to DONE on the next edge.
  - Throughput: one element per cycle when exu_ready stays high.
- DONE:
  - vec_valid_out=1; vec_result=result_buf; exu_valid=0; exu_res_ready=0.
  - Hold both outputs stable until vec_ready_in.
  - On vec_valid_out&vec_ready_in, go to IDLE; vec_valid_out=0 and vec_ready_out=1 from the next cycle.
  - No new vector is accepted in the same cycle as the handoff.
- Latency:
  - Accept at edge k; first exu_valid is visible after edge k, i.e. from cycle k+1.
  - vec_valid_out rises one cycle after the edge that completes the last result handshake.
  - An all-zero mask gives vec_valid_out in cycle k+1.
- Masked-off result elements are exactly 16'h0000 (exp(-inf) for softmax).
- Pointers are log2(NUM_ELEMS) wide with an extra done bit. The next-set-bit search is combinational over the latched mask; the final advance sets the done bit, with no wrap to element 0.
- An exu_res_valid arriving in IDLE or DONE is not accepted (exu_res_ready=0). It must never occur; the bench asserts this.

Test Plan:
- Reset then idle -> vec_ready_out=1, vec_valid_out=0, exu_valid=0, vec_result=0.
- Full mask 0xFFFFFFFF, element i = 16'h3F80+i, exp unit model with fixed 3-cycle latency, result = operand^16'h00FF -> 32 issues on consecutive cycles; vec_result[i] = (16'h3F80+i)^16'h00FF; vec_valid_out one cycle after the 32nd result handshake.
- Mask 0x80000001 -> only elements 0 and 31 issued (exactly 2 exu handshakes); all other result elements are 16'h0000.
- Mask 0 -> no exu_valid ever; vec_valid_out=1 in cycle k+1 with vec_result all zero.
- Random exu_ready/exu_res_valid stalls and vec_ready_in held low for 5 cycles -> exu_operand stable while stalled, no lost or duplicated elements, vec_result stable until accepted; then IDLE.
- RST asserted mid-RUN after 10 issues -> next cycle: IDLE outputs; a following vector completes correctly with no stale data.
